sink_counter_c: RTL

//  Output stage directly downstream of the transaction layer. Drains FIFO D0/D1 via pop_d0/pop_d1.

---
 rtl/sink_counter_c_pkg.sv | 18 +
 rtl/sink_counter_c_sat_counter.sv | 31 +++
 rtl/sink_counter_c.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sink_counter_c_pkg.sv
// Shared definitions for the sink counter: FSM states, read index codes
// and the position of the routing bit inside each FIFO word.
package sink_counter_c_pkg;

  typedef enum logic {
    S_COUNT = 1'b0,
    S_RESP  = 1'b1
  } state_t;

  localparam logic [1:0] IDX_D0  = 2'd0;
  localparam logic [1:0] IDX_D1  = 2'd1;
  localparam logic [1:0] IDX_SUM = 2'd2;
  localparam logic [1:0] IDX_RSV = 2'd3;

  // D0 words must carry 0 here, D1 words must carry 1.
  localparam int ROUTE_BIT = 4;

endpackage

// File: rtl/sink_counter_c_sat_counter.sv
// Saturating up-counter for one lane. A clear loads the current beat
// (0 or 1) so a word arriving in the clear cycle is not lost.
module sat_counter_c #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          sat_hit
);

  localparam logic [CW-1:0] MAX = '1;

  // Increment attempted while already at the ceiling; a clear overrides it.
  assign sat_hit = inc & ~clr & (count == MAX);

  // Lane count: clear-with-beat, saturating increment, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    if (reset)
      count <= '0;
    else if (clr)
      count <= CW'(inc);
    else if (inc && (count != MAX))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/sink_counter_c.sv
// Output stage behind the transaction layer: pops FIFO D0/D1, counts the
// words actually delivered per lane, checks each word's routing bit and
// answers registered count reads while the layer FSM is idle.
module sink_counter_c
  import sink_counter_c_pkg::*;
#(
  parameter int DW = 6,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          drain_en,
  input  logic          d0_empty,
  input  logic          d1_empty,
  input  logic [DW-1:0] d0_data,
  input  logic          d0_valid,
  input  logic [DW-1:0] d1_data,
  input  logic          d1_valid,
  input  logic          idle_in,
  input  logic          clr,
  input  logic          req,
  input  logic [1:0]    idx,
  output logic          pop_d0,
  output logic          pop_d1,
  output logic [CW:0]   resp_data,
  output logic          resp_valid,
  output logic          ovf,
  output logic          route_err
);

  logic [CW-1:0] cnt_d0;
  logic [CW-1:0] cnt_d1;
  logic          sat_d0;
  logic          sat_d1;
  logic [CW:0]   sum;
  logic [CW:0]   sel_value;
  logic [CW:0]   resp_q;
  logic          route_hit;
  logic          accept;
  state_t        state_q;
  state_t        state_d;

  // Only the routing bit of each word matters here; the payload is folded
  // into a deliberately unused net.
  logic unused_data;
  assign unused_data = ^{d0_data, d1_data};

  // Pops go straight out; reset forces them low without waiting for a clock.
  assign pop_d0 = drain_en & ~d0_empty & ~reset;
  assign pop_d1 = drain_en & ~d1_empty & ~reset;

  sat_counter_c #(.CW(CW)) u_cnt_d0 (
    .clk     (clk),
    .reset   (reset),
    .inc     (d0_valid),
    .clr     (clr),
    .count   (cnt_d0),
    .sat_hit (sat_d0)
  );

  sat_counter_c #(.CW(CW)) u_cnt_d1 (
    .clk     (clk),
    .reset   (reset),
    .inc     (d1_valid),
    .clr     (clr),
    .count   (cnt_d1),
    .sat_hit (sat_d1)
  );

  // Widened before adding, so the sum can never wrap.
  assign sum = {1'b0, cnt_d0} + {1'b0, cnt_d1};

  assign route_hit = (d0_valid &  d0_data[ROUTE_BIT])
                   | (d1_valid & ~d1_data[ROUTE_BIT]);

  assign accept = req & idle_in;

  // Sticky flags; a clear still lets this cycle's route check land.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf       <= 1'b0;
      route_err <= 1'b0;
    end else if (clr) begin
      ovf       <= 1'b0;
      route_err <= route_hit;
    end else begin
      ovf       <= ovf | sat_d0 | sat_d1;
      route_err <= route_err | route_hit;
    end
  end

  // Read mux over the pre-edge counter values, so a read coincident with a
  // clear returns the value before clearing.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    sel_value = '0;
    unique case (idx)
      IDX_D0:  sel_value = {1'b0, cnt_d0};
      IDX_D1:  sel_value = {1'b0, cnt_d1};
      IDX_SUM: sel_value = sum;
      IDX_RSV: sel_value = '0;
      default: sel_value = '0;
    endcase
  end

  // FSM state and the captured response value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_COUNT;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        resp_q <= sel_value;
    end
  end

  // Next state and outputs: a read is served the cycle after it is accepted,
  // and a new accepted read can follow immediately.
  always_comb begin
    state_d    = S_COUNT;
    resp_valid = 1'b0;
    resp_data  = '0;
    unique case (state_q)
      S_COUNT: begin
        if (accept)
          state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_data  = resp_q;
        if (accept)
          state_d = S_RESP;
      end
      default: state_d = S_COUNT;
    endcase
  end

endmodule
